// File: rtl/lb_host_arb.sv
// ---------------------------------------------------------------------------
// lb_host_arb
//
// Two-master arbiter for the shared localbus in the lb_clk domain.
//   Master 0 (network host) issues single-cycle strobes with no backpressure
//   and always wins. Master 1 (on-chip sequencer) holds its request until
//   m1_ready and only gets the slots master 0 leaves idle.
//   Reads are tagged with their owner in a small FIFO so that each return is
//   routed only to the master that issued it. Returns arrive in issue order.
//   Protocol errors (tag overflow, orphan return) and the longest master-1
//   wait are reported as status.
//
// Ports
//   lb_clk, lb_rstn          clock, asynchronous active-low reset
//   m0_*                     master 0 strobes/operands, read return
//   m1_*                     master 1 requests/operands, ready, read return
//   bus_addr/wdata/write/read registered shared-bus request
//   bus_rdata/bus_rvalid     shared-bus read return (in issue order)
//   clr_stat                 synchronous clear of error flags and m1_wait_max
//   err_overflow, err_orphan sticky protocol error flags
//   m1_wait_max              longest master-1 wait in cycles (saturating)
// ---------------------------------------------------------------------------
module lb_host_arb #(
    parameter int AW        = 24,
    parameter int DW        = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic          lb_clk,
    input  logic          lb_rstn,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_write,
    input  logic          m0_read,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_write,
    input  logic          m1_read,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_write,
    output logic          bus_read,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_rvalid,
    input  logic          clr_stat,
    output logic          err_overflow,
    output logic          err_orphan,
    output logic [15:0]   m1_wait_max
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

    logic [TAG_DEPTH-1:0] r_tags;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic [15:0]          r_wait_cnt;

    logic w_m0_any;
    logic w_m1_req;
    logic w_m1_xfer;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_push_tag;
    logic w_head;
    logic w_ovf_evt;
    logic w_orph_evt;

    assign w_m0_any  = m0_write | m0_read;
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);

    // Ready ignores a same-cycle pop on purpose: keeps m1_ready off the
    // bus_rvalid path at the cost of occasionally losing one slot.
    assign m1_ready  = ~w_m0_any & ~w_full;
    assign w_m1_req  = m1_write | m1_read;
    assign w_m1_xfer = w_m1_req & m1_ready;

    // A return only pops when there is a tag to pop; otherwise it is an orphan.
    assign w_pop      = bus_rvalid & ~w_empty;
    assign w_orph_evt = bus_rvalid & w_empty;

    // A full FIFO still accepts a master-0 tag if the head leaves this cycle.
    assign w_ovf_evt  = m0_read & w_full & ~w_pop;
    assign w_push     = w_m0_any ? (m0_read & ~w_ovf_evt) : (w_m1_xfer & m1_read);
    assign w_push_tag = ~w_m0_any;
    assign w_head     = r_tags[r_rptr];

    // Shared bus request register: master 0 first, then a master-1 transfer,
    // otherwise strobes drop and the operands keep their last value.
    always_ff @(posedge lb_clk or negedge lb_rstn) begin
        if (!lb_rstn) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_write <= 1'b0;
            bus_read  <= 1'b0;
        end else if (w_m0_any) begin
            bus_addr  <= m0_addr;
            bus_wdata <= m0_wdata;
            bus_read  <= m0_read;
            bus_write <= m0_write & ~m0_read;
        end else if (w_m1_xfer) begin
            bus_addr  <= m1_addr;
            bus_wdata <= m1_wdata;
            bus_read  <= m1_read;
            bus_write <= m1_write & ~m1_read;
        end else begin
            bus_write <= 1'b0;
            bus_read  <= 1'b0;
        end
    end

    // Owner-tag FIFO. When full with a simultaneous pop, the write slot equals
    // the head slot; the head is consumed combinationally before the overwrite.
    always_ff @(posedge lb_clk or negedge lb_rstn) begin
        if (!lb_rstn) begin
            r_tags  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wptr] <= w_push_tag;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Return routing by head tag; read data is held between returns.
    always_ff @(posedge lb_clk or negedge lb_rstn) begin
        if (!lb_rstn) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= w_pop & ~w_head;
            m1_rvalid <= w_pop & w_head;
            if (w_pop & ~w_head) begin
                m0_rdata <= bus_rdata;
            end
            if (w_pop & w_head) begin
                m1_rdata <= bus_rdata;
            end
        end
    end

    // Status: sticky errors (a set beats a clear) and the master-1 wait
    // statistic, which tracks the running wait and its maximum.
    always_ff @(posedge lb_clk or negedge lb_rstn) begin
        if (!lb_rstn) begin
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
            r_wait_cnt   <= '0;
            m1_wait_max  <= '0;
        end else begin
            err_overflow <= w_ovf_evt  | (err_overflow & ~clr_stat);
            err_orphan   <= w_orph_evt | (err_orphan   & ~clr_stat);

            if (w_m1_req & ~m1_ready) begin
                if (r_wait_cnt != 16'hFFFF) begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                end
            end else if (w_m1_xfer) begin
                r_wait_cnt <= '0;
            end

            if (clr_stat) begin
                m1_wait_max <= '0;
            end else if (r_wait_cnt > m1_wait_max) begin
                m1_wait_max <= r_wait_cnt;
            end
        end
    end

endmodule

// File: doc/lb_host_arb.md
# lb_host_arb

Two-master arbiter for the shared ghostbus localbus (`lb_addr`/`lb_wdata`/`lb_write`/`lb_rdata`/`lb_rvalid`) in `lb_clk`.
- Master 0 is the network host (rtefi p2 port). It issues strobes with no backpressure and always has priority.
- Master 1 is an on-chip sequencer (e.g. a boot/init engine). It uses a ready handshake and gets only the bus slots master 0 leaves idle.
- The block registers the shared bus outputs and tags each read with its owner, so read data returns only to the master that issued the read.
- It also reports protocol errors and master-1 starvation.

## Interface
Parameters:
- `AW`, 24, address width
- `DW`, 32, data width
- `TAG_DEPTH`, 4, number of outstanding reads tracked; must be a power of 2, ≥2

Ports:
- `lb_clk`  in  1  localbus clock; the only clock
- `lb_rstn`  in  1  asynchronous, active-low reset
- `m0_addr`  in  AW  master 0 address
- `m0_wdata`  in  DW  master 0 write data
- `m0_write`  in  1  master 0 write strobe, single cycle
- `m0_read`  in  1  master 0 read strobe, single cycle
- `m0_rdata`  out  DW  master 0 read data
- `m0_rvalid`  out  1  master 0 read data valid
- `m1_addr`  in  AW  master 1 address
- `m1_wdata`  in  DW  master 1 write data
- `m1_write`  in  1  master 1 write request, held until accepted
- `m1_read`  in  1  master 1 read request, held until accepted
- `m1_ready`  out  1  master 1 request accepted this cycle
- `m1_rdata`  out  DW  master 1 read data
- `m1_rvalid`  out  1  master 1 read data valid
- `bus_addr`  out  AW  shared bus address (registered)
- `bus_wdata`  out  DW  shared bus write data (registered)
- `bus_write`  out  1  shared bus write strobe (registered)
- `bus_read`  out  1  shared bus read strobe (registered)
- `bus_rdata`  in  DW  shared bus read data
- `bus_rvalid`  in  1  shared bus read data valid; returns are in issue order
- `clr_stat`  in  1  synchronous clear of the error flags and `m1_wait_max`
- `err_overflow`  out  1  sticky: master 0 read issued while the tag FIFO was full
- `err_orphan`  out  1  sticky: `bus_rvalid` arrived with no outstanding tag
- `m1_wait_max`  out  16  longest master 1 wait observed, in cycles; saturates at 16'hFFFF

## Operation
Reset values: every output is 0. The tag FIFO is empty (count 0).

Request handling:
- If a master asserts read and write together, the read wins and the write is dropped.
- `m0_any = m0_write | m0_read`.
- `m1_ready = ~m0_any & (count < TAG_DEPTH)`. This is combinational and conservative: a same-cycle pop does not count toward free space.
- A master 1 request transfers on `(m1_write|m1_read) & m1_ready`.
- In a cycle with `m0_any`, master 0's addr/wdata/strobe are registered onto the bus.
- Otherwise, if master 1 transfers, master 1's addr/wdata/strobe are registered onto the bus.
- Otherwise `bus_write` and `bus_read` register 0, and `bus_addr`/`bus_wdata` hold their previous values.
- Master 1 is only held off, never dropped: while not ready it must keep its request and operands stable.

Tag FIFO (depth `TAG_DEPTH`, 1 bit per entry, 0 = master 0, 1 = master 1):
- Push: when a read is registered onto the bus (same edge that sets `bus_read`), the owner bit is pushed.
- Pop: on a cycle with `bus_rvalid`.
- Push and pop in the same cycle leave the count unchanged and both take effect.
- Master 0 read with count == `TAG_DEPTH` and no same-cycle pop: the read is still forwarded, the tag is not pushed, and `err_overflow` is set.
- `bus_rvalid` with count == 0: `bus_rdata` is discarded, no master rvalid is raised, and `err_orphan` is set.

Return routing:
- On `bus_rvalid` with head tag 0: the next edge sets `m0_rvalid` = 1 for one cycle and `m0_rdata <= bus_rdata`.
- On `bus_rvalid` with head tag 1: the same, on `m1_rvalid`/`m1_rdata`.
- Each `mX_rdata` holds its value until that master's next return.

Starvation statistic:
- A 16-bit counter increments each cycle that master 1 is requesting and not ready, saturating at 16'hFFFF.
- The counter clears on the cycle the request transfers.
- `m1_wait_max <= max(m1_wait_max, counter)` each cycle.

Clear:
- `clr_stat` clears `err_overflow`, `err_orphan` and `m1_wait_max`.
- If an error event occurs in the same cycle as `clr_stat`, the set wins.

## Timing
- Request to bus strobe: 1 cycle, for either master.
- `bus_rvalid` to `mX_rvalid`: 1 cycle.
- Total read latency for a master: 2 cycles plus the slave read delay. The design uses a slave delay of 3, giving 5 cycles.
- Master 1 minimum wait: 0 cycles when master 0 is idle and the FIFO is not full.
- Back-to-back master 1 transfers every cycle are allowed.
- Reset asserted mid-operation: bus strobes drop immediately (asynchronously) and outstanding tags are discarded.
  - After reset, a late `bus_rvalid` with an empty FIFO raises `err_orphan`. This is the expected behaviour.

## Test plan
- Reset then idle: all outputs 0. Release `lb_rstn` and run 10 cycles: still 0, `m1_ready` = 1.
- `m0_write` with addr 24'h000010, wdata 32'hceceface at cycle N: `bus_write` = 1 with the same values at N+1, exactly 1 cycle wide.
- Collision: master 0 and master 1 both write at cycle N.
  - Required: `m1_ready` = 0 at N, master 0 on the bus at N+1.
  - Master 1 accepted at N+1 and on the bus at N+2.
  - `m1_wait_max` = 1.
- Interleaved reads with slave delay 3:
  - Stimulus: master 0 reads addr 4, master 1 reads 24'h004000, master 0 reads addr 5 on consecutive cycles; slave returns 8'hcc, 16'h1234, 32'hceceface.
  - Required: `m0_rvalid` returns 8'hcc then 32'hceceface, and `m1_rvalid` returns 16'h1234, each 5 cycles after its request.
- FIFO full: master 1 issues 4 reads with the slave stalled.
  - Required: `m1_ready` = 0 on the 5th request.
  - A further master 0 read sets `err_overflow`.
  - After one `bus_rvalid`, `m1_ready` returns to 1.
- Orphan return: `bus_rvalid` with the FIFO empty sets `err_orphan` and raises no master rvalid. `clr_stat` clears it on the next edge.
